// File: rtl/sklansky_seq_pkg.sv
// Shared types and helpers for the sequential Sklansky wide adder.
package sklansky_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Word-index width; kept at least one bit so WORDS=1 still has a legal index.
    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/Sklansky_par.sv
// N-bit Sklansky parallel-prefix adder with carry-in; purely combinational.
module Sklansky_par #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum_c,
    output logic         cout_c
);

    localparam int unsigned LV = (N > 1) ? $clog2(N) : 0;

    logic [LV:0][N-1:0] gl;
    logic [LV:0][N-1:0] pl;
    logic [N:0]         carry_c;

    // Level l: every bit with bit l of its index set absorbs the group ending
    // just below its 2^l-aligned block, so after LV levels gl[LV][i] = G[i:0].
    always_comb begin
        int j;
        j     = 0;
        gl    = '0;
        pl    = '0;
        gl[0] = a & b;
        pl[0] = a ^ b;
        for (int l = 0; l < int'(LV); l++) begin
            gl[l+1] = gl[l];
            pl[l+1] = pl[l];
            for (int i = 0; i < int'(N); i++) begin
                if (((i >> l) & 1) == 1) begin
                    j = ((i >> l) << l) - 1;
                    gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][j]);
                    pl[l+1][i] = pl[l][i] & pl[l][j];
                end
            end
        end
    end

    assign carry_c = {gl[LV] | (pl[LV] & {N{cin}}), cin};
    assign sum_c   = pl[0] ^ carry_c[N-1:0];
    assign cout_c  = carry_c[N];

endmodule

// File: rtl/sklansky_seq_wide_adder.sv
// Wide adder that streams CHUNK-bit words through one Sklansky prefix adder,
// chaining the carry through a register, with valid/ready on both sides.
module sklansky_seq_wide_adder
    import sklansky_seq_pkg::*;
#(
    parameter int unsigned CHUNK = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHUNK*WORDS-1:0]   a,
    input  logic [CHUNK*WORDS-1:0]   b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHUNK*WORDS-1:0]   sum,
    output logic                     cout,
    output logic                     busy
);

    localparam int unsigned W     = CHUNK * WORDS;
    localparam int unsigned IDX_W = idx_width(WORDS);

    state_t                        state;
    state_t                        state_d;
    logic [IDX_W-1:0]              idx;
    logic                          carry;
    logic                          last_c;
    logic                          accept_c;
    logic [WORDS-1:0][CHUNK-1:0]   op_a;
    logic [WORDS-1:0][CHUNK-1:0]   op_b;
    logic [WORDS-1:0][CHUNK-1:0]   sum_q;
    logic [CHUNK-1:0]              chunk_sum_c;
    logic                          chunk_cout_c;

    Sklansky_par #(
        .N (CHUNK)
    ) u_chunk (
        .a      (op_a[idx]),
        .b      (op_b[idx]),
        .cin    (carry),
        .sum_c  (chunk_sum_c),
        .cout_c (chunk_cout_c)
    );

    // Next-state logic.
    always_comb begin
        state_d  = state;
        accept_c = 1'b0;
        last_c   = (idx == IDX_W'(WORDS - 1));
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, word index, carry chain, result and handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            sum_q     <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
            if (accept_c) begin
                carry <= cin;
                idx   <= '0;
            end
            if (state == RUN) begin
                sum_q[idx] <= chunk_sum_c;
                carry      <= chunk_cout_c;
                if (last_c) begin
                    cout <= chunk_cout_c;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    // Operands are sampled only on the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst && accept_c) begin
            op_a <= a;
            op_b <= b;
        end
    end

    assign sum = W'(sum_q);

endmodule
